// File: rtl/rr_arbiter_fsm.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_fsm
// Description : 4-way round-robin arbiter with release handling and a
//               grant-hold timeout that traps into an error state.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_fsm #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT  = 2'd1,
        S_ER   = 2'd2
    } state_t;

    localparam logic [7:0] c_HOLD_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_last_ptr;
    logic [1:0] w_last_ptr_nxt;
    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_cnt_nxt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] w_id_nxt;
    logic       w_busy_nxt;
    logic       w_err_nxt;
    logic [1:0] w_pick;
    logic       w_release;
    logic       w_issue;

    // Search starts just after the last winner, so the holder is checked last.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        w_pick = r_last_ptr;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = r_last_ptr + 2'(k);
            if (!found && req[idx]) begin
                w_pick = idx;
                found  = 1'b1;
            end
        end
    end

    assign w_release = done | ~req[grant_id];

    always_comb begin
        w_state_nxt    = r_state;
        w_last_ptr_nxt = r_last_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_gnt_nxt      = gnt;
        w_id_nxt       = grant_id;
        w_busy_nxt     = busy;
        w_err_nxt      = err;
        w_issue        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_issue = 1'b1;
                end
            end
            S_GNT: begin
                if (w_release) begin
                    if (|req) begin
                        w_issue = 1'b1;
                    end else begin
                        w_state_nxt    = S_IDLE;
                        w_hold_cnt_nxt = 8'd0;
                        w_gnt_nxt      = 4'b0000;
                        w_id_nxt       = 2'd0;
                        w_busy_nxt     = 1'b0;
                    end
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt    = S_ER;
                    w_hold_cnt_nxt = 8'd0;
                    w_gnt_nxt      = 4'b0000;
                    w_id_nxt       = 2'd0;
                    w_busy_nxt     = 1'b0;
                    w_err_nxt      = 1'b1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
            end
            S_ER: begin
                if (req == 4'b0000) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_hold_cnt_nxt = 8'd0;
                w_gnt_nxt      = 4'b0000;
                w_id_nxt       = 2'd0;
                w_busy_nxt     = 1'b0;
                w_err_nxt      = 1'b0;
            end
        endcase

        // Every grant issue, including a re-grant to the same holder, restarts the hold count.
        if (w_issue) begin
            w_state_nxt    = S_GNT;
            w_last_ptr_nxt = w_pick;
            w_hold_cnt_nxt = 8'd0;
            w_gnt_nxt      = 4'b0001 << w_pick;
            w_id_nxt       = w_pick;
            w_busy_nxt     = 1'b1;
            w_err_nxt      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last_ptr <= 2'd3;
            r_hold_cnt <= 8'd0;
            gnt        <= 4'b0000;
            grant_id   <= 2'd0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_ptr <= w_last_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            gnt        <= w_gnt_nxt;
            grant_id   <= w_id_nxt;
            busy       <= w_busy_nxt;
            err        <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_fsm
// Description : Self-checking bench for rr_arbiter_fsm (TIMEOUT = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] grant_id;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    rr_arbiter_fsm #(.TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .grant_id (grant_id),
        .busy     (busy),
        .err      (err)
    );

    typedef struct packed {
        logic       r;
        logic [3:0] q;
        logic       d;
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        logic       e;
    } vec_t;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        logic       e;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic d,
                                input logic [3:0] g, input logic [1:0] id,
                                input logic b, input logic e);
        vec_t v;
        v = '{r, q, d, g, id, b, e};
        return v;
    endfunction

    // Inputs are held for one clock; the outputs registered at that edge are checked.
    task automatic apply(input string tag, input logic r, input logic [3:0] q, input logic d,
                         input logic [3:0] g, input logic [1:0] id, input logic b, input logic e);
        exp_t x;
        rst  = r;
        req  = q;
        done = d;
        sb.push_back('{g, id, b, e});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        n_checks++;
        if ({gnt, grant_id, busy, err} !== {x.g, x.id, x.b, x.e}) begin
            n_err++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b err=%b, want gnt=%b id=%0d busy=%b err=%b",
                     tag, gnt, grant_id, busy, err, x.g, x.id, x.b, x.e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;

        // reset with all requests asserted
        tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0));
        // single requester, done-release to idle
        tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0));
        tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0));
        tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0));
        // full rotation with done every third cycle
        tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 2'd1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0010, 2'd1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0010, 2'd1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 2'd2, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0100, 2'd2, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0100, 2'd2, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 2'd3, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b1000, 2'd3, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b1000, 2'd3, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 0));
        // withdrawals, sole-requester re-grant, wrap-around search
        tbl.push_back(mk(0, 4'b1110, 0, 4'b0010, 2'd1, 1, 0));
        tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 2'd1, 1, 0));
        tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0));
        tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk(0, 4'b1001, 0, 4'b1000, 2'd3, 1, 0));
        tbl.push_back(mk(0, 4'b1001, 1, 4'b0001, 2'd0, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0));

        foreach (tbl[i])
            apply($sformatf("vec%0d", i), tbl[i].r, tbl[i].q, tbl[i].d,
                  tbl[i].g, tbl[i].id, tbl[i].b, tbl[i].e);

        // timeout: grant visible exactly 16 cycles, then error until req drops
        apply("to_rst", 1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        for (int i = 0; i < 16; i++)
            apply($sformatf("to_hold%0d", i), 0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        apply("to_err", 0, 4'b0100, 0, 4'b0000, 2'd0, 0, 1);
        apply("to_err_done_ignored", 0, 4'b0100, 1, 4'b0000, 2'd0, 0, 1);
        apply("to_recover", 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        // release in the same cycle the timeout would fire
        for (int i = 0; i < 16; i++)
            apply($sformatf("rel_hold%0d", i), 0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        apply("rel_at_last", 0, 4'b0110, 1, 4'b0010, 2'd1, 1, 0);
        apply("rel_withdraw", 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        // reset mid-grant restores the pointer to 3
        apply("mid_gnt", 0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0);
        apply("mid_rst", 1, 4'b1000, 0, 4'b0000, 2'd0, 0, 0);
        apply("post_rst", 0, 4'b1010, 0, 4'b0010, 2'd1, 1, 0);
        apply("post_rst_idle", 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        // reset while in error state
        for (int i = 0; i < 16; i++)
            apply($sformatf("er_hold%0d", i), 0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
        apply("er_enter", 0, 4'b0001, 0, 4'b0000, 2'd0, 0, 1);
        apply("er_rst", 1, 4'b0001, 0, 4'b0000, 2'd0, 0, 0);
        apply("er_post_rst", 0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
